vowel_word_counter: RTL and testbench

//  Streaming vowel classifier/counter: accepts one letter code per handshake, flags vowels,

---
 rtl/vowel_pkg.sv | 50 +++++
 rtl/vowel_classify.sv | 22 ++
 rtl/vowel_word_counter.sv | 121 ++++++++++++
 tb/tb_vowel_word_counter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vowel_pkg.sv
// Shared letter codes, FSM state type and vowel classification helper for the
// vowel word counter.
package vowel_pkg;

    localparam int unsigned CODE_A = 1;
    localparam int unsigned CODE_B = 2;
    localparam int unsigned CODE_C = 3;
    localparam int unsigned CODE_D = 4;
    localparam int unsigned CODE_E = 5;
    localparam int unsigned CODE_F = 6;
    localparam int unsigned CODE_G = 7;
    localparam int unsigned CODE_H = 8;
    localparam int unsigned CODE_I = 9;
    localparam int unsigned CODE_J = 10;
    localparam int unsigned CODE_K = 11;
    localparam int unsigned CODE_L = 12;
    localparam int unsigned CODE_M = 13;
    localparam int unsigned CODE_N = 14;
    localparam int unsigned CODE_O = 15;
    localparam int unsigned CODE_P = 16;
    localparam int unsigned CODE_Q = 17;
    localparam int unsigned CODE_R = 18;
    localparam int unsigned CODE_S = 19;
    localparam int unsigned CODE_T = 20;
    localparam int unsigned CODE_U = 21;
    localparam int unsigned CODE_V = 22;
    localparam int unsigned CODE_W = 23;
    localparam int unsigned CODE_X = 24;
    localparam int unsigned CODE_Y = 25;
    localparam int unsigned CODE_Z = 26;

    // Word FSM: between words, accumulating a word, holding a finished result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WORD = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    // True for A, E, I, O, U and optionally Y; every non-letter code is false.
    function automatic logic is_vowel(input logic [31:0] code, input logic y_is_vowel);
        logic v;
        v = (code == CODE_A) || (code == CODE_E) || (code == CODE_I) ||
            (code == CODE_O) || (code == CODE_U);
        if (y_is_vowel && (code == CODE_Y)) begin
            v = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/vowel_classify.sv
// Combinational classifier: marks a letter code as letter/separator and vowel.
module vowel_classify
    import vowel_pkg::*;
#(
    parameter int LW         = 6,
    parameter bit Y_IS_VOWEL = 1'b0
) (
    input  logic [LW-1:0] code,
    output logic          is_vowel_o,
    output logic          is_letter_o
);

    logic [31:0] code_ext;

    // Codes 1..26 are letters; everything else (0 and 27 upward) is a separator.
    always_comb begin
        code_ext    = 32'(code);
        is_letter_o = (code_ext >= CODE_A) && (code_ext <= CODE_Z);
        is_vowel_o  = is_vowel(code_ext, Y_IS_VOWEL);
    end

endmodule

// File: rtl/vowel_word_counter.sv
// Streaming per-word letter/vowel counter with a valid/ready result port and a
// saturating running total of vowels.
module vowel_word_counter
    import vowel_pkg::*;
#(
    parameter int LW         = 6,
    parameter int CW         = 4,
    parameter int TW         = 16,
    parameter bit Y_IS_VOWEL = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [LW-1:0] in_code,
    output logic          vowel,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [CW-1:0] word_letters,
    output logic [CW-1:0] word_vowels,
    output logic [TW-1:0] total_vowels
);

    state_t        state_q, state_d;
    logic [CW-1:0] letters_q, letters_d;
    logic [CW-1:0] vowels_q, vowels_d;
    logic [TW-1:0] total_q, total_d;
    logic          vowel_q, vowel_d;

    logic          code_is_vowel;
    logic          code_is_letter;
    logic          accept;

    vowel_classify #(
        .LW         (LW),
        .Y_IS_VOWEL (Y_IS_VOWEL)
    ) u_classify (
        .code        (in_code),
        .is_vowel_o  (code_is_vowel),
        .is_letter_o (code_is_letter)
    );

    // Handshake and result port are decoded straight from the state register.
    always_comb begin
        in_ready     = (state_q != S_EMIT);
        word_valid   = (state_q == S_EMIT);
        accept       = in_valid && in_ready;
        word_letters = letters_q;
        word_vowels  = vowels_q;
        total_vowels = total_q;
        vowel        = vowel_q;
    end

    // Next-state logic for the word FSM, per-word counters and running totals.
    always_comb begin
        state_d   = state_q;
        letters_d = letters_q;
        vowels_d  = vowels_q;
        total_d   = total_q;
        vowel_d   = vowel_q;

        if (accept) begin
            // Separators are never vowels, so this also clears the flag on them.
            vowel_d = code_is_vowel;
            if (code_is_vowel && (total_q != {TW{1'b1}})) begin
                total_d = total_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept && code_is_letter) begin
                    state_d   = S_WORD;
                    letters_d = CW'(1);
                    vowels_d  = code_is_vowel ? CW'(1) : '0;
                end
            end
            S_WORD: begin
                if (accept) begin
                    if (code_is_letter) begin
                        if (letters_q != {CW{1'b1}}) begin
                            letters_d = letters_q + CW'(1);
                        end
                        if (code_is_vowel && (vowels_q != {CW{1'b1}})) begin
                            vowels_d = vowels_q + CW'(1);
                        end
                    end else begin
                        // Counts freeze here and are presented on word_* until taken.
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (word_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset discarding any partial or pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            letters_q <= '0;
            vowels_q  <= '0;
            total_q   <= '0;
            vowel_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            letters_q <= letters_d;
            vowels_q  <= vowels_d;
            total_q   <= total_d;
            vowel_q   <= vowel_d;
        end
    end

endmodule

// File: tb/tb_vowel_word_counter.sv
// Self-checking bench: two instances (Y as consonant / Y as vowel) fed the same
// stream, compared each cycle against a word-level reference model.
module tb_vowel_word_counter;

    localparam int LW = 6;
    localparam int CW = 4;
    localparam int TW = 16;
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [LW-1:0] in_code;
    logic          word_ready;

    logic          in_ready[2];
    logic          vowel[2];
    logic          word_valid[2];
    logic [CW-1:0] word_letters[2];
    logic [CW-1:0] word_vowels[2];
    logic [TW-1:0] total_vowels[2];

    int total_cnt;
    int bad_cnt;

    // Reference model state (index = Y_IS_VOWEL setting)
    bit m_pend;
    bit m_just_reset;
    int m_cur_letters;
    int m_cur_vowels[2];
    int m_res_letters;
    int m_res_vowels[2];
    int m_total[2];
    bit m_vowel[2];

    vowel_word_counter #(.LW(LW), .CW(CW), .TW(TW), .Y_IS_VOWEL(1'b0)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready[0]),
        .in_code      (in_code),
        .vowel        (vowel[0]),
        .word_valid   (word_valid[0]),
        .word_ready   (word_ready),
        .word_letters (word_letters[0]),
        .word_vowels  (word_vowels[0]),
        .total_vowels (total_vowels[0])
    );

    vowel_word_counter #(.LW(LW), .CW(CW), .TW(TW), .Y_IS_VOWEL(1'b1)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready[1]),
        .in_code      (in_code),
        .vowel        (vowel[1]),
        .word_valid   (word_valid[1]),
        .word_ready   (word_ready),
        .word_letters (word_letters[1]),
        .word_vowels  (word_vowels[1]),
        .total_vowels (total_vowels[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_is_vowel(input int code, input bit y);
        string s;
        byte   ch;
        s = y ? "AEIOUY" : "AEIOU";
        if (code < 1 || code > 26) return 1'b0;
        ch = byte'(8'h40 + code);
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == ch) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock: check handshake/result outputs, clock, update model, check registered outputs.
    task automatic cycle();
        bit acc;
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("in_ready[y=%0d]", k), int'(in_ready[k]), int'(!m_pend));
            check_val($sformatf("word_valid[y=%0d]", k), int'(word_valid[k]), int'(m_pend));
            if (m_pend) begin
                check_val($sformatf("word_letters[y=%0d]", k), int'(word_letters[k]), m_res_letters);
                check_val($sformatf("word_vowels[y=%0d]", k), int'(word_vowels[k]), m_res_vowels[k]);
            end
            if (m_just_reset) begin
                check_val($sformatf("rst_letters[y=%0d]", k), int'(word_letters[k]), 0);
                check_val($sformatf("rst_vowels[y=%0d]", k), int'(word_vowels[k]), 0);
            end
        end
        acc = in_valid && !m_pend;
        @(posedge clk);
        m_just_reset = 1'b0;
        if (reset) begin
            m_pend = 1'b0;
            m_just_reset = 1'b1;
            m_cur_letters = 0;
            for (int k = 0; k < 2; k++) begin
                m_cur_vowels[k] = 0;
                m_total[k] = 0;
                m_vowel[k] = 1'b0;
            end
        end else if (m_pend) begin
            if (word_ready) m_pend = 1'b0;
        end else if (acc) begin
            for (int k = 0; k < 2; k++) begin
                m_vowel[k] = m_is_vowel(int'(in_code), k[0]);
                if (m_vowel[k]) m_total[k] = sat(m_total[k] + 1, TMAX);
            end
            if (in_code >= 1 && in_code <= 26) begin
                m_cur_letters++;
                for (int k = 0; k < 2; k++) m_cur_vowels[k] += int'(m_vowel[k]);
            end else if (m_cur_letters > 0) begin
                m_pend = 1'b1;
                m_res_letters = sat(m_cur_letters, CMAX);
                for (int k = 0; k < 2; k++) begin
                    m_res_vowels[k] = sat(m_cur_vowels[k], CMAX);
                    m_cur_vowels[k] = 0;
                end
                m_cur_letters = 0;
            end
        end
        #1;
        $display("cyc rst=%0b v=%0b code=%0d wr=%0b acc=%0b -> wv=%0b/%0b wl=%0d wv0=%0d wv1=%0d tot=%0d/%0d",
                 reset, in_valid, in_code, word_ready, acc && !reset,
                 word_valid[0], word_valid[1], word_letters[0], word_vowels[0], word_vowels[1],
                 total_vowels[0], total_vowels[1]);
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("vowel[y=%0d]", k), int'(vowel[k]), int'(m_vowel[k]));
            check_val($sformatf("total[y=%0d]", k), int'(total_vowels[k]), m_total[k]);
        end
    endtask

    // Present a code and keep it valid until the model says it was accepted.
    task automatic send(input int code);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_code  = LW'(code);
        for (int n = 0; n < 50 && !done; n++) begin
            done = !m_pend;
            cycle();
        end
        if (!done) check_val("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int cat_word[4];
        total_cnt = 0;
        bad_cnt = 0;
        m_pend = 1'b0;
        m_just_reset = 1'b0;
        m_cur_letters = 0;
        m_res_letters = 0;
        for (int k = 0; k < 2; k++) begin
            m_cur_vowels[k] = 0;
            m_res_vowels[k] = 0;
            m_total[k] = 0;
            m_vowel[k] = 1'b0;
        end
        reset = 1'b1;
        in_valid = 1'b0;
        in_code = '0;
        word_ready = 1'b1;
        @(posedge clk);
        do_reset();
        idle(1);

        // 1: "CAT" + separator
        cat_word = '{3, 1, 20, 0};
        foreach (cat_word[i]) send(cat_word[i]);
        idle(2);

        // 2: "MY" + separator (Y differs between the two instances)
        send(13); send(25); send(0);
        idle(2);

        // 3: "IO" + separator with downstream stalled and input held valid
        word_ready = 1'b0;
        send(9); send(15); send(0);
        in_valid = 1'b1;
        in_code = LW'(1);
        idle(5);
        word_ready = 1'b1;
        idle(2);
        in_valid = 1'b0;
        send(0);
        idle(2);

        // 4: 20 x 'E' saturates per-word counters
        do_reset();
        for (int i = 0; i < 20; i++) send(5);
        send(0);
        idle(2);

        // 5: leading / repeated separators, then "A" + separator 63
        send(0); send(31); send(63); send(27); idle(2);
        send(1); send(63);
        idle(2);

        // 6: reset mid-word and during a pending result
        send(1); send(5);
        do_reset();
        idle(1);
        word_ready = 1'b0;
        send(1); send(0);
        idle(1);
        do_reset();
        word_ready = 1'b1;
        idle(1);
        send(21); send(0);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            reset = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            word_ready = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 9);
            if (r < 7) in_code = LW'($urandom_range(1, 26));
            else if (r < 8) in_code = '0;
            else in_code = LW'($urandom_range(27, 63));
            cycle();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        word_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
